next_pc_unit: RTL
=================

# next_pc_unit

Parametrised next-PC unit for the single-issue MIPS datapath: replaces the fixed two-input jump/sequential selector with a registered program counter, four-way target formation (sequential, branch, jump, jump-register) and stall-safe buffering of a redirect. It sits at the head of the fetch stage, feeding instruction memory from `pc`, and takes redirect requests from decode/execute.

## Interface
- `WIDTH`, 32, address width in bits.
- `JUMP_W`, 28, width of the jump-target field, already shifted left 2; 3 ≤ JUMP_W < WIDTH.
- `RESET_VEC`, 32'h0040_0000, PC value after reset; low 2 bits must be 0.

- `clk` in 1, single clock, rising edge.
- `reset` in 1, synchronous, active-high.
- `stall` in 1, hold PC this cycle.
- `redirect_valid` in 1, redirect request this cycle.
- `redirect_sel` in 2, 01 branch, 10 jump, 11 jump-register, 00 sequential (treated as no redirect).
- `branch_offset` in WIDTH, sign-extended word offset.
- `jump_target` in JUMP_W, byte-address low bits of jump target.
- `reg_target` in WIDTH, jump-register target.
- `pc` out WIDTH, current fetch address (registered).
- `pc_plus4` out WIDTH, `pc + 4` modulo 2^WIDTH (combinational from `pc`).
- `pending` out 1, a buffered redirect is waiting for stall release.
- `misaligned` out 1, one-cycle registered pulse: jump-register target rejected.

## Operation
- Target formation from current `pc`:
  - branch: `pc_plus4 + (branch_offset << 2)`, modulo 2^WIDTH.
  - jump: `{pc_plus4[WIDTH-1:JUMP_W], jump_target}`; upper bits come from `pc_plus4`, never zero-filled.
  - jump-register: `reg_target`; if `reg_target[1:0] != 0` the request is dropped (as if `redirect_valid`=0) and `misaligned` pulses.
- Effective request = `redirect_valid` && sel≠00 && not dropped.
- States: RUN, PEND.
  - RUN, no stall: request → `pc` ← target; else `pc` ← `pc_plus4`.
  - RUN, stall: `pc` holds; request → capture target into pending register, go PEND.
  - PEND, stall: `pc` holds; new request overwrites pending target (newest wins).
  - PEND, no stall: request this cycle → `pc` ← new target; else `pc` ← pending target; go RUN.
- `pending` = 1 exactly in PEND.
- Misaligned drop in PEND does not disturb the already-pending target.

## Timing
- Reset (sync, cycle of assertion): `pc`=RESET_VEC, state RUN, `pending`=0, `misaligned`=0, pending register cleared; reset in PEND discards the buffered redirect.
- Latency: request sampled at edge N, `pc` shows target after edge N (1 cycle) when unstalled.
- Stalled request appears on `pc` one edge after the first unstalled cycle.
- `misaligned` is high for exactly the cycle after the offending request's edge; back-to-back bad requests give back-to-back pulses.
- `pc` wrap: 0xFFFF_FFFC advances to 0x0000_0000, no flag.
- Branch/jump targets computed from the held `pc` while stalled, so capture time equals issue time.

## Structure
- Package `mips_pc_pkg`: `redirect_sel` encodings (SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG), state enum (RUN, PEND), default RESET_VEC.
- Sub-module `pc_target_calc`: combinational target formation and alignment check, parametrised by WIDTH/JUMP_W; top holds PC register, pending register, FSM, misaligned flop.

## Test plan
- Reset, stall=0, no redirect for 3 cycles -> `pc` 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C.
- `pc`=0x9000_0010, jump, `jump_target`=28'h000_0040 -> next `pc`=0x9000_0040.
- `pc`=0x0040_0020, branch, `branch_offset`=0xFFFF_FFFE -> next `pc`=0x0040_001C.
- Stall held 3 cycles; jreg 0x0050_0000 in cycle 1, jreg 0x0060_0000 in cycle 2 -> `pc` constant, `pending`=1 from cycle 2; release -> `pc`=0x0060_0000, `pending`=0.
- `pc`=0x0040_0000, jreg `reg_target`=0x0050_0002 -> `pc`=0x0040_0004, `misaligned`=1 for one cycle.
- `pc`=0xFFFF_FFFC unstalled -> 0x0000_0000; reset asserted while PEND -> `pc`=0x0040_0000, `pending`=0, buffered target never applied.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared encodings and defaults for the next-PC unit
package mips_pc_pkg;
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_JREG   = 2'b11
  } sel_e;
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0040_0000;
endpackage

// File: rtl/next_pc_unit_pc_target_calc.sv
// pc_target_calc: forms the redirect target from the current pc and flags unaligned jump-register targets
module pc_target_calc
  import mips_pc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int JUMP_W = 28
) (
  input  logic [WIDTH-1:0]  pc_i,
  input  logic [1:0]        sel_i,
  input  logic [WIDTH-1:0]  branch_offset_i,
  input  logic [JUMP_W-1:0] jump_target_i,
  input  logic [WIDTH-1:0]  reg_target_i,
  output logic [WIDTH-1:0]  pc_plus4_o,
  output logic [WIDTH-1:0]  target_o,
  output logic              unaligned_o
);
  // jump keeps the region bits of pc+4; sequential falls back to pc+4
  always_comb begin
    pc_plus4_o  = pc_i + WIDTH'(4);
    target_o    = sel_i == SEL_BRANCH ? pc_plus4_o + (branch_offset_i << 2) :
                  sel_i == SEL_JUMP   ? {pc_plus4_o[WIDTH-1:JUMP_W], jump_target_i} :
                  sel_i == SEL_JREG   ? reg_target_i : pc_plus4_o;
    unaligned_o = sel_i == SEL_JREG && reg_target_i[1:0] != 2'b00;
  end
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered fetch PC with branch/jump/jreg redirects buffered across stalls
module next_pc_unit
  import mips_pc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int JUMP_W = 28,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [WIDTH-1:0]  branch_offset,
  input  logic [JUMP_W-1:0] jump_target,
  input  logic [WIDTH-1:0]  reg_target,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_plus4,
  output logic              pending,
  output logic              misaligned
);
  logic [WIDTH-1:0] pc_q, pend_q, target;
  state_e           state_q;
  logic             mis_q, unaligned, bad, req;

  pc_target_calc #(.WIDTH(WIDTH), .JUMP_W(JUMP_W)) u_calc (
    .pc_i            (pc_q),
    .sel_i           (redirect_sel),
    .branch_offset_i (branch_offset),
    .jump_target_i   (jump_target),
    .reg_target_i    (reg_target),
    .pc_plus4_o      (pc_plus4),
    .target_o        (target),
    .unaligned_o     (unaligned)
  );

  // a misaligned jreg is dropped entirely, so it never touches pc or the pending target
  always_comb begin
    bad = redirect_valid && unaligned;
    req = redirect_valid && redirect_sel != SEL_SEQ && !unaligned;
  end

  // PC register, pending buffer and RUN/PEND state; newest stalled request wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      state_q <= RUN;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= bad;
      if (state_q == RUN) begin
        if (!stall) pc_q <= req ? target : pc_plus4;
        else if (req) begin
          pend_q  <= target;
          state_q <= PEND;
        end
      end else if (stall) begin
        if (req) pend_q <= target;
      end else begin
        pc_q    <= req ? target : pend_q;
        state_q <= RUN;
      end
    end
  end

  assign pc         = pc_q;
  assign pending    = state_q == PEND;
  assign misaligned = mis_q;
endmodule
